// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - loader byte stream and instruction fetch signal bundle
interface imem_loader_if;
    logic        i_byte_valid;
    logic        o_byte_ready;
    logic [7:0]  i_byte_data;
    logic [31:0] i_pc;
    logic [31:0] o_instruction;

    // Side that feeds bytes and fetches instructions
    modport master (
        output i_byte_valid,
        input  o_byte_ready,
        output i_byte_data,
        output i_pc,
        input  o_instruction
    );

    // Loader / instruction memory side
    modport slave (
        input  i_byte_valid,
        output o_byte_ready,
        input  i_byte_data,
        input  i_pc,
        output o_instruction
    );
endinterface

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - instruction RAM with framed serial program loader
module imem_loader #(
    parameter int ADDR_W = 10
) (
    input  logic            i_clk,
    input  logic            i_rst_l,
    imem_loader_if.slave    bus,
    output logic            o_cpu_rst_l,
    output logic            o_busy,
    output logic            o_error,
    output logic [ADDR_W:0] o_words_loaded
);

    localparam logic [31:0] NOP       = 32'h0000_0013;
    localparam logic [32:0] MAX_WORDS = 33'd1 << ADDR_W;
    localparam int          DEPTH     = 1 << ADDR_W;

    typedef enum logic [2:0] {
        ST_HDR,
        ST_DATA,
        ST_CSUM,
        ST_RUN,
        ST_ERROR
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [1:0]      byte_cnt;
    logic [23:0]     shift;
    logic [ADDR_W:0] n_words;
    logic [31:0]     csum;
    logic [31:0]     ram [DEPTH];

    logic            accept;
    logic            word_done;
    logic [31:0]     word;
    logic            last_word;
    logic            ram_we;
    logic            pc_ok;

    // Bytes arrive least significant first; the 4th byte completes the word
    assign accept    = bus.i_byte_valid && bus.o_byte_ready;
    assign word_done = accept && (byte_cnt == 2'd3);
    assign word      = {bus.i_byte_data, shift};
    assign last_word = (o_words_loaded + (ADDR_W+1)'(1)) == n_words;

    assign o_busy           = (state == ST_HDR) || (state == ST_DATA) || (state == ST_CSUM);
    assign o_error          = (state == ST_ERROR);
    assign bus.o_byte_ready = o_busy;

    // Frame sequencing: header, payload words, checksum, then terminal RUN/ERROR
    always_comb begin
        state_nxt = state;
        ram_we    = 1'b0;
        case (state)
            ST_HDR: begin
                if (word_done) begin
                    if ({1'b0, word} > MAX_WORDS) begin
                        state_nxt = ST_ERROR;
                    end else if (word == 32'd0) begin
                        state_nxt = ST_CSUM;
                    end else begin
                        state_nxt = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (word_done) begin
                    ram_we = 1'b1;
                    if (last_word) begin
                        state_nxt = ST_CSUM;
                    end
                end
            end
            ST_CSUM: begin
                if (word_done) begin
                    state_nxt = (word == csum) ? ST_RUN : ST_ERROR;
                end
            end
            default: begin
                state_nxt = state;
            end
        endcase
    end

    // State register
    always_ff @(posedge i_clk or negedge i_rst_l) begin
        if (!i_rst_l) begin
            state <= ST_HDR;
        end else begin
            state <= state_nxt;
        end
    end

    // Word assembly, header latch, running checksum and processor reset release
    always_ff @(posedge i_clk or negedge i_rst_l) begin
        if (!i_rst_l) begin
            byte_cnt       <= 2'd0;
            shift          <= 24'd0;
            n_words        <= '0;
            csum           <= 32'd0;
            o_words_loaded <= '0;
            o_cpu_rst_l    <= 1'b0;
        end else begin
            o_cpu_rst_l <= (state_nxt == ST_RUN);
            if (accept) begin
                byte_cnt <= byte_cnt + 2'd1;
                shift    <= {bus.i_byte_data, shift[23:8]};
            end
            if (word_done && (state == ST_HDR)) begin
                n_words <= word[ADDR_W:0];
            end
            if (ram_we) begin
                csum           <= csum ^ word;
                o_words_loaded <= o_words_loaded + (ADDR_W+1)'(1);
            end
        end
    end

    // Payload write; index never exceeds DEPTH-1 because N is bounded at the header
    always_ff @(posedge i_clk) begin
        if (ram_we) begin
            ram[o_words_loaded[ADDR_W-1:0]] <= word;
        end
    end

    // Fetch path: only aligned, in-range addresses read RAM, and only once running
    assign pc_ok = (state == ST_RUN) && (bus.i_pc[1:0] == 2'b00) &&
                   (bus.i_pc[31:ADDR_W+2] == '0);
    assign bus.o_instruction = pc_ok ? ram[bus.i_pc[ADDR_W+1:2]] : NOP;

endmodule

// File: doc/imem_loader.md
# imem_loader

Instruction memory with a built-in serial program loader. It sits directly upstream of the pipelined processor's IF stage. It receives a framed byte stream and writes the payload into a word-addressed instruction RAM, holding the processor in reset while it does so. Once the checksum verifies, it releases the processor, then serves combinational instruction reads from the processor's PC.

## Interface
Parameters:
- ADDR_W, 10, log2 of RAM depth in 32-bit words (capacity 2^ADDR_W words).

Ports:
- i_clk  in  1  clock.
- i_rst_l  in  1  asynchronous, active-low reset.
- i_byte_valid  in  1  loader byte present.
- o_byte_ready  out  1  loader can accept a byte.
- i_byte_data  in  8  loader byte.
- i_pc  in  32  fetch address from processor.
- o_instruction  out  32  instruction at i_pc.
- o_cpu_rst_l  out  1  processor reset, active-low; registered.
- o_busy  out  1  load in progress (HDR/DATA/CSUM states).
- o_error  out  1  load failed; sticky until reset.
- o_words_loaded  out  ADDR_W+1  payload words written so far.

## Operation
- Stream frame, all words little-endian (first byte = bits [7:0]):
  - header word N;
  - N payload words;
  - checksum word = XOR of all payload words (0 when N=0).
- A byte transfers only on a clock edge with i_byte_valid && o_byte_ready.
- A 2-bit byte counter and a 24-bit shift register assemble each word. The word is complete on the 4th accepted byte.
- FSM states: HDR, DATA, CSUM, RUN, ERROR.
- HDR: on the 4th byte, latch N.
  - N > 2^ADDR_W -> ERROR.
  - N = 0 -> CSUM.
  - Otherwise -> DATA.
- DATA: on each 4th byte:
  - write the word to RAM[o_words_loaded[ADDR_W-1:0]];
  - XOR it into the running checksum;
  - increment o_words_loaded.
  - After the Nth word -> CSUM.
- CSUM: on the 4th byte, compare with the running checksum.
  - Match -> RUN, with o_cpu_rst_l set to 1 on the same edge.
  - Mismatch -> ERROR.
- RUN and ERROR are terminal until i_rst_l.
- o_byte_ready = 1 in HDR/DATA/CSUM and 0 in RUN/ERROR. It is decoded from registered state only and never depends on i_byte_valid.
- o_busy = state is HDR, DATA or CSUM.
- o_error = state is ERROR.
- Read path (combinational, async RAM read):
  - o_instruction = RAM[i_pc[ADDR_W+1:2]] when all of:
    - state == RUN;
    - i_pc[1:0] == 0;
    - i_pc[31:ADDR_W+2] == 0.
  - Otherwise o_instruction = 32'h0000_0013 (addi x0,x0,0).
- RAM has no reset and no initial contents. Only DATA-state writes modify it.

## Timing
- Reset (asynchronous assert, synchronous release) puts every register into a defined state:
  - state = HDR, byte counter = 0, N = 0, running checksum = 0;
  - o_words_loaded = 0, o_cpu_rst_l = 0;
  - as a result o_byte_ready = 1, o_busy = 1, o_error = 0, o_instruction = NOP.
- Reset mid-load aborts the frame. The partial word is discarded and loading restarts at HDR. RAM keeps stale data, but it is unreadable until the next RUN.
- Reset in RUN drops o_cpu_rst_l to 0 immediately (asynchronously).
- RAM write takes effect at the edge accepting a word's 4th byte. The word is readable combinationally in the following cycle, once in RUN.
- o_cpu_rst_l rises the cycle after the final checksum byte handshake. The processor's first fetch is the next rising edge with i_pc = 0.
- Minimum frame time is 4·(N+2) cycles at full throughput. Gaps in i_byte_valid stall the frame with no state change.
- o_words_loaded saturates at N ≤ 2^ADDR_W. The RAM write index for the last word is 2^ADDR_W−1 with no wrap.
- A byte offered in RUN/ERROR is not accepted and has no effect.

## Test plan
- ADDR_W=10; stream N=2, words 0x00500093 and 0x00100113, then checksum 0x00400180 -> o_cpu_rst_l=1 one cycle after the last byte, o_words_loaded=2. i_pc=0 -> 0x00500093; i_pc=4 -> 0x00100113; i_pc=2 -> 0x00000013.
- Same frame with checksum 0x00400181 -> o_error=1, o_byte_ready=0, o_cpu_rst_l stays 0, o_instruction=0x00000013.
- Header N=1025 -> ERROR on the edge of the 4th header byte. Further bytes are not accepted.
- N=1 word 0xDEADBEEF (checksum 0xDEADBEEF), with i_byte_valid driven 1,0,0,1,... random gaps -> exactly 12 handshakes, RUN reached. i_pc=0 -> 0xDEADBEEF; i_pc=0x1000 -> NOP.
- Assert i_rst_l low after 2 of 3 payload words, then send a fresh N=1 frame -> o_words_loaded reads 0 during reset, then 1. RAM[0] holds the new word.
- N=0 with checksum 0 -> RUN after 8 bytes; i_pc=0 -> stale/undefined RAM accepted. Then pulse i_rst_l low in RUN -> o_cpu_rst_l falls with no clock edge.
